// File: rtl/udp_send.sv
// udp_send: buffers one application payload frame and emits it as a UDP segment (8-byte header + payload).
//   Optional feature macro: UDP_SEND_CHECKSUM_EN (adds the pseudo-header checksum; otherwise checksum field is 0x0000).
//   Ports:
//     clk, reset                     rising-edge clock, synchronous active-high reset
//     udpdata_tdata/tvalid/tlast_in  payload byte stream from the application
//     udpdata_tready_out             payload byte accepted (IDLE and LOAD only)
//     src_port_in, dest_port_in      UDP ports, captured on the first payload byte
//     src_ip_in, dst_ip_in           IPv4 addresses, pseudo-header checksum only
//     udp_axis_tdata/tvalid/tlast_out, udp_axis_tready_in  UDP segment stream toward the IP layer
//     oversize_out                   one-cycle pulse when a frame was truncated to FIFO_DEPTH bytes
module udp_send #(
   parameter int FIFO_DEPTH = 2048
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  udpdata_tdata_in,
   input  logic        udpdata_tvalid_in,
   input  logic        udpdata_tlast_in,
   output logic        udpdata_tready_out,
   input  logic [15:0] src_port_in,
   input  logic [15:0] dest_port_in,
   input  logic [31:0] src_ip_in,
   input  logic [31:0] dst_ip_in,
   output logic [7:0]  udp_axis_tdata_out,
   output logic        udp_axis_tvalid_out,
   output logic        udp_axis_tlast_out,
   input  logic        udp_axis_tready_in,
   output logic        oversize_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, LOAD, HDR, PAYLOAD} state_t;
   state_t state;
   logic [7:0] mem [FIFO_DEPTH];
   logic [7:0] mem_q, next_byte;
   logic [AW:0] n;
   logic [AW-1:0] rd_ptr, rd_next;
   logic [15:0] src_q, dst_q, pos, pos_n, len, csum;
   logic in_xfer, out_xfer, full, store;
   assign udpdata_tready_out = !reset && (state == IDLE || state == LOAD);
   assign in_xfer = udpdata_tvalid_in && udpdata_tready_out;
   assign out_xfer = udp_axis_tvalid_out && udp_axis_tready_in;
   assign full = n == (AW + 1)'(FIFO_DEPTH);
   assign store = in_xfer && !full;
   assign len = 16'(n) + 16'd8;
   assign pos_n = pos + 16'd1;
   // pos indexes the byte currently held on the output; bytes 8.. come from the buffer
   assign next_byte = pos_n == 16'd1 ? src_q[7:0] :
                      pos_n == 16'd2 ? dst_q[15:8] :
                      pos_n == 16'd3 ? dst_q[7:0] :
                      pos_n == 16'd4 ? len[15:8] :
                      pos_n == 16'd5 ? len[7:0] :
                      pos_n == 16'd6 ? csum[15:8] :
                      pos_n == 16'd7 ? csum[7:0] : mem_q;
   // mem_q always mirrors mem[rd_ptr], so a payload byte is ready on every transfer cycle
   assign rd_next = (reset || state == IDLE) ? '0 :
                    (out_xfer && pos_n >= 16'd8 && !udp_axis_tlast_out) ? rd_ptr + 1'b1 : rd_ptr;
   always_ff @(posedge clk) begin
      if (store) mem[n[AW-1:0]] <= udpdata_tdata_in;
      mem_q <= mem[rd_next];
   end
`ifdef UDP_SEND_CHECKSUM_EN
   logic [31:0] acc, src_ip_q, dst_ip_q, sum;
   logic [16:0] fold1;
   logic [15:0] fold2;
   // payload bytes alternate high/low halves of 16-bit words; odd tail is implicitly zero-padded
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         src_ip_q <= '0;
         dst_ip_q <= '0;
      end else if (store) begin
         acc <= (state == IDLE ? 32'd0 : acc) + (n[0] ? {24'd0, udpdata_tdata_in} : {16'd0, udpdata_tdata_in, 8'd0});
         if (state == IDLE) begin
            src_ip_q <= src_ip_in;
            dst_ip_q <= dst_ip_in;
         end
      end
   end
   // length is counted twice: pseudo-header and UDP header
   assign sum = acc + 32'(src_ip_q[31:16]) + 32'(src_ip_q[15:0]) + 32'(dst_ip_q[31:16]) + 32'(dst_ip_q[15:0])
              + 32'h11 + 32'(len) + 32'(len) + 32'(src_q) + 32'(dst_q);
   assign fold1 = 17'(sum[15:0]) + 17'(sum[31:16]);
   assign fold2 = fold1[15:0] + 16'(fold1[16]);
   assign csum = ~fold2 == 16'h0000 ? 16'hFFFF : ~fold2;
`else
   logic unused_ip;
   assign unused_ip = ^{src_ip_in, dst_ip_in};
   assign csum = 16'h0000;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         n <= '0;
         rd_ptr <= '0;
         pos <= '0;
         src_q <= '0;
         dst_q <= '0;
         udp_axis_tdata_out <= '0;
         udp_axis_tvalid_out <= 1'b0;
         udp_axis_tlast_out <= 1'b0;
         oversize_out <= 1'b0;
      end else begin
         rd_ptr <= rd_next;
         oversize_out <= 1'b0;
         case (state)
            IDLE, LOAD: if (in_xfer) begin
               if (state == IDLE) begin
                  src_q <= src_port_in;
                  dst_q <= dest_port_in;
               end
               if (!full) n <= n + 1'b1;
               if (udpdata_tlast_in) begin
                  state <= HDR;
                  pos <= '0;
                  udp_axis_tvalid_out <= 1'b1;
                  udp_axis_tlast_out <= 1'b0;
                  udp_axis_tdata_out <= state == IDLE ? src_port_in[15:8] : src_q[15:8];
                  oversize_out <= full;
               end else begin
                  state <= LOAD;
               end
            end
            default: if (out_xfer) begin
               if (udp_axis_tlast_out) begin
                  state <= IDLE;
                  n <= '0;
                  udp_axis_tvalid_out <= 1'b0;
                  udp_axis_tlast_out <= 1'b0;
                  udp_axis_tdata_out <= '0;
               end else begin
                  pos <= pos_n;
                  udp_axis_tdata_out <= next_byte;
                  udp_axis_tlast_out <= pos_n == len - 16'd1;
                  if (pos_n == 16'd8) state <= PAYLOAD;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/udp_send.md
UDP_SEND -- requirements
Module: udp_send

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2048, meaning maximum stored payload bytes per frame (power of two, >= 16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port udpdata_tdata_in  input  8  application payload byte.
REQ-005 SHALL have port udpdata_tvalid_in  input  1  payload byte valid.
REQ-006 SHALL have port udpdata_tlast_in  input  1  last payload byte of frame.
REQ-007 SHALL have port udpdata_tready_out  output  1  block accepts payload byte.
REQ-008 SHALL have port src_port_in  input  16  UDP source port.
REQ-009 SHALL have port dest_port_in  input  16  UDP destination port.
REQ-010 SHALL have port src_ip_in  input  32  IPv4 source address, pseudo-header only.
REQ-011 SHALL have port dst_ip_in  input  32  IPv4 destination address, pseudo-header only.
REQ-012 SHALL have port udp_axis_tdata_out  output  8  UDP segment byte toward IP layer.
REQ-013 SHALL have port udp_axis_tvalid_out  output  1  segment byte valid.
REQ-014 SHALL have port udp_axis_tlast_out  output  1  last segment byte.
REQ-015 SHALL have port udp_axis_tready_in  input  1  IP layer accepts byte.
REQ-016 SHALL have port oversize_out  output  1  one-cycle pulse: frame truncated.

Function
REQ-017 SHALL implement states IDLE, LOAD, HDR, PAYLOAD; input transfer = tvalid_in & tready_out; output transfer = tvalid_out & tready_in.
REQ-018 SHALL drive udpdata_tready_out high only in IDLE and LOAD.
REQ-019 SHALL, on the first input transfer in IDLE, capture src_port_in, dest_port_in, src_ip_in, dst_ip_in, store the byte, set count N=1, and enter LOAD (or HDR if tlast).
REQ-020 SHALL in LOAD store each transferred byte and increment N; on the tlast transfer enter HDR.
REQ-021 SHALL, once N reaches FIFO_DEPTH without tlast, accept and discard further bytes until tlast, then pulse oversize_out for one cycle and enter HDR with N=FIFO_DEPTH.
REQ-022 SHALL assert udp_axis_tvalid_out on the cycle after the tlast input transfer (one-cycle latency).
REQ-023 SHALL emit in HDR, MSB first: source port (2), destination port (2), length = N+8 as 16-bit (2), checksum (2); then enter PAYLOAD.
REQ-024 SHALL emit in PAYLOAD the N stored bytes in arrival order, asserting udp_axis_tlast_out only on byte N, then return to IDLE.
REQ-025 SHALL hold tdata/tvalid/tlast out stable while tvalid_out & !tready_in.
REQ-026 SHALL emit back-to-back bytes with no bubbles while tready_in stays high.
REQ-027 SHALL drive udp_axis_tvalid_out low in IDLE and LOAD.
REQ-028 SHALL ignore port/IP input changes after capture until the next frame.

Reset
REQ-029 SHALL on reset enter IDLE, clear N, buffer pointers, captured fields and checksum accumulator, within one clock.
REQ-030 SHALL reset outputs: udp_axis_tdata_out=0, udp_axis_tvalid_out=0, udp_axis_tlast_out=0, oversize_out=0, udpdata_tready_out=0 during reset cycle.
REQ-031 SHALL discard any partially loaded or partially sent frame on reset mid-operation; no further bytes of it emitted.

Configuration
REQ-032 SHALL, with UDP_SEND_CHECKSUM_EN defined, emit ones-complement of 16-bit ones-complement sum over pseudo-header (src IP, dst IP, 0x0011, length), UDP header with checksum field 0, and payload (odd N padded with 0x00); result 0x0000 transmitted as 0xFFFF.
REQ-033 SHALL, with UDP_SEND_CHECKSUM_EN undefined, emit checksum 0x0000 and omit accumulator logic; src_ip_in/dst_ip_in unused.
REQ-034 SHALL compute the checksum incrementally during LOAD so REQ-022 latency holds in both builds.

Verification
REQ-035 SHALL cover: ports 0x1234->0x5678, payload 0x01,0x02,0x03(last) -> out 12 34 56 78 00 0B cc cc 01 02 03, tlast on 03, tvalid one cycle after input tlast.
REQ-036 SHALL cover: tready_in toggled 1010... during 20-byte frame -> identical byte sequence, data stable when stalled, tlast once.
REQ-037 SHALL cover: FIFO_DEPTH=16, 20-byte input -> 24-byte output, length 0x0018, oversize_out single pulse.
REQ-038 SHALL cover: checksum build, IPs 192.168.1.1->192.168.1.2, ports 0x1234->0x5678, payload "hi" -> checksum equals software reference; undefined build -> 0x0000.
REQ-039 SHALL cover: reset asserted mid-PAYLOAD of frame A, then frame B sent -> no A bytes after reset, B output correct.
